// File: rtl/act_pkg.sv
// Shared constants and types for the thresholded-ReLU activation stage.
package act_pkg;

   localparam int BIT_WIDTH = 8;
   localparam int LANES     = 4;
   localparam int ROW_CNT_W = 8;

   typedef logic [BIT_WIDTH-1:0] lane_t;

   localparam lane_t DEF_THRESH = 8'h0A;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} act_state_e;

   // Data and clamp mask travel through the output FIFO as one word
   typedef struct packed {
      logic [LANES*BIT_WIDTH-1:0] data;
      logic [LANES-1:0]           mask;
   } fifo_entry_t;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation: unsigned threshold clamp to zero, or bypass.
module act_lane
   import act_pkg::*;
(
   input  lane_t in,
   input  lane_t thresh,
   input  logic  bypass,
   output lane_t out,
   output logic  zeroed
);

   assign zeroed = !bypass && (in < thresh);
   assign out    = zeroed ? '0 : in;

endmodule

// File: rtl/activation_controller.sv
// Tile sequencer for the 4-lane activation stage: accepts drain rows,
// clamps them per lane and buffers results in a 2-entry output FIFO.
module activation_controller
   import act_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [ROW_CNT_W-1:0]       num_rows,
   input  lane_t                      cfg_thresh,
   input  logic                       cfg_bypass,
   output logic                       busy,
   output logic                       done,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*BIT_WIDTH-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*BIT_WIDTH-1:0] out_data,
   output logic [LANES-1:0]           zero_mask
);

   act_state_e           state;
   logic [ROW_CNT_W-1:0] remaining;
   lane_t                thresh;
   logic                 bypass;
   logic [1:0]           fifo_count;
   fifo_entry_t          head;
   fifo_entry_t          tail;
   fifo_entry_t          act_entry;
   logic                 accept;
   logic                 pop;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_lane u_lane (
         .in     (in_data[i*BIT_WIDTH +: BIT_WIDTH]),
         .thresh (thresh),
         .bypass (bypass),
         .out    (act_entry.data[i*BIT_WIDTH +: BIT_WIDTH]),
         .zeroed (act_entry.mask[i])
      );
   end

   // Depends only on registered state, so no path from in_valid/out_ready
   assign in_ready  = (state == RUN) && (remaining != '0) && (fifo_count != 2'd2);
   assign accept    = in_valid && in_ready;
   assign out_valid = (fifo_count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_data  = head.data;
   assign zero_mask = head.mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         thresh    <= DEF_THRESH;
         bypass    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= num_rows;
                  thresh    <= cfg_thresh;
                  bypass    <= cfg_bypass;
                  if (num_rows == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  remaining <= remaining - ROW_CNT_W'(1);
                  if (remaining == ROW_CNT_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_count == 2'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE: state <= IDLE;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // A push never coincides with a full FIFO because in_ready is low then
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_count <= 2'd0;
         head       <= '0;
         tail       <= '0;
      end else begin
         if (pop) begin
            if (fifo_count == 2'd2) head <= tail;
            else if (accept)        head <= act_entry;
         end else if (accept) begin
            if (fifo_count == 2'd0) head <= act_entry;
            else                    tail <= act_entry;
         end
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: doc/activation_controller.md
Name: activation_controller

Overview:
Sequences the 4-lane thresholded-ReLU activation stage for one output tile. It accepts accumulator row vectors from the systolic-array drain over a valid/ready handshake and applies the per-lane threshold clamp, or bypasses it. Results are buffered in a 2-entry output FIFO toward the writeback path. It counts rows against a programmed tile length and reports busy/done to the top-level controller.

Parameters:
BIT_WIDTH, 8, width of one lane value (unsigned)
LANES, 4, lanes per row vector
ROW_CNT_W, 8, width of row counter / num_rows
DEF_THRESH, 8'h0A, threshold loaded at reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a tile when IDLE
num_rows  input  ROW_CNT_W  rows in tile; sampled on accepted start
cfg_thresh  input  BIT_WIDTH  clamp threshold; sampled on accepted start
cfg_bypass  input  1  1 = pass data unmodified; sampled on accepted start
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at tile completion
in_valid  input  1  row vector valid
in_ready  output  1  controller can accept a row
in_data  input  LANES*BIT_WIDTH  row vector; lane i = bits [i*BIT_WIDTH +: BIT_WIDTH]
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_data  output  LANES*BIT_WIDTH  activated row vector, same lane packing
zero_mask  output  LANES  bit i set if lane i of head was clamped to zero

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Every register clears on assertion regardless of state.
- Reset values: state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, zero_mask=0, FIFO count=0, row counter=0. The threshold register resets to DEF_THRESH and bypass resets to 0.
- Reset asserted mid-tile discards all buffered rows. No done pulse is produced for that tile.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE: start=1 latches num_rows, cfg_thresh and cfg_bypass. If num_rows=0 the next state is DONE; otherwise it is RUN. start is ignored in every other state.
- RUN: in_ready = (remaining>0) && (fifo_count<2). It is registered-state only, with no combinational path from out_ready or in_valid. A beat is accepted when in_valid && in_ready, and each accept decrements remaining. The accept of the last row moves the FSM to DRAIN in the next cycle.
- DRAIN: in_ready=0. The FSM moves to DONE in the cycle after fifo_count reaches 0.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE. busy is 0 in DONE.
- Lane function, unsigned compare:
  - bypass=0: out = (in < thresh) ? 0 : in, and mask bit = (in < thresh).
  - bypass=1: out = in, and mask bit = 0.
  - Example: thresh=0x0A gives 0x09→0x00 and 0x0A→0x0A.
- Latency: a row accepted in cycle N appears at the FIFO head with out_valid=1 in cycle N+1. That holds if the FIFO was empty or the previous head popped in cycle N.
- FIFO: 2 entries; data and mask are stored together.
  - Push and pop in the same cycle leave the count unchanged, so sustained throughput is 1 row/cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and zero_mask are held stable.
- Full: with fifo_count=2, in_ready=0 in the next cycle. Empty: out_valid=0, and out_data holds its last value (don't-care).
- Config changes on cfg_* during a tile have no effect until the next accepted start.
- Width: remaining is ROW_CNT_W bits, so the largest tile is 2^ROW_CNT_W−1 rows. The counter never wraps because accepts stop at 0.

Decomposition:
- Package act_pkg holds:
  - constant DEF_THRESH;
  - typedef act_state_e (IDLE, RUN, DRAIN, DONE);
  - typedef lane_t, equal to logic [BIT_WIDTH-1:0].
- One sub-module, act_lane, is natural. It is combinational: inputs in, thresh, bypass; outputs out, zeroed. The controller instantiates it LANES times via generate.

Test Plan:
- Basic tile: thresh=0x0A, bypass=0, num_rows=3, rows {09,0A,FF,00}, {10,01,0B,0A}, {00,00,00,00}, out_ready=1 → outputs {00,0A,FF,00} mask 1001, {10,00,0B,0A} mask 0010, {00,00,00,00} mask 1111. Each output is 1 cycle after its accept; done pulses once; busy falls with done.
- Backpressure: num_rows=4 with out_ready=0 → in_ready drops after 2 accepts and head data stays stable. Then out_ready=1 → all 4 rows emerge in order, followed by done.
- Bypass and config isolation: bypass=1, num_rows=2, rows containing 0x05 → 0x05 passes and mask=0. Changing cfg_thresh/cfg_bypass mid-tile does not alter results.
- Zero rows and start filtering: num_rows=0 → done 1 cycle after start, with in_ready never high. A start pulse during RUN is ignored and the row count is unaffected.
- Reset mid-operation: rst_n low while 2 rows are buffered in RUN → immediately out_valid=0, in_ready=0, busy=0 and thresh=0x0A, with no done pulse. A following tile runs normally.
- Throughput: num_rows=8, in_valid=1 and out_ready=1 continuously → 8 consecutive accept cycles, 8 consecutive output cycles, and done 2 cycles after the last output.
